// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared ALU: arbitrates between the requesters, runs a
// single operation at a time, and holds the registered result until the consumer takes it.
module alu_share_arbiter #(
    parameter bit FIX_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_gin,
    input  logic [31:0] alu_sum,
    input  logic        alu_zout,
    input  logic        alu_nin,
    input  logic        alu_vin,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_sum,
    output logic        rsp_z,
    output logic        rsp_n,
    output logic        rsp_v,
    output logic        rsp_err
);

    localparam logic [2:0] OP_BAD = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        last_id;
    logic        owner_id;
    logic        winner;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [2:0]  op_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        winner = 1'b0;
        if (FIX_PRIO)
            winner = ~req0_valid;
        else if (req0_valid && req1_valid)
            winner = ~last_id;
        else
            winner = req1_valid;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !winner;
    assign req1_ready = (state == IDLE) && req1_valid && winner;

    // The shared ALU only sees live operands while this block owns it.
    assign alu_a   = (state == EXEC) ? opa_q : '0;
    assign alu_b   = (state == EXEC) ? opb_q : '0;
    assign alu_gin = (state == EXEC) ? op_q  : '0;

    // NOTE: operand and response registers are reset too, so an aborted op leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_id   <= 1'b1;
            owner_id  <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_z     <= 1'b0;
            rsp_n     <= 1'b0;
            rsp_v     <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        opa_q    <= winner ? req1_a  : req0_a;
                        opb_q    <= winner ? req1_b  : req0_b;
                        op_q     <= winner ? req1_op : req0_op;
                        owner_id <= winner;
                        last_id  <= winner;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_id    <= owner_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                    if (op_q == OP_BAD) begin
                        rsp_err <= 1'b1;
                        rsp_sum <= '0;
                        rsp_z   <= 1'b1;
                        rsp_n   <= 1'b0;
                        rsp_v   <= 1'b0;
                    end else begin
                        rsp_err <= 1'b0;
                        rsp_sum <= alu_sum;
                        rsp_z   <= alu_zout;
                        rsp_n   <= alu_nin;
                        rsp_v   <= alu_vin;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic, checked each cycle
// against a timestamp-based transaction model and a behavioural ALU.
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_sum;
    logic [2:0]  alu_gin;
    logic        alu_zout, alu_nin, alu_vin;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_n, rsp_v, rsp_err;
    logic [31:0] rsp_sum;

    logic        fp_req0_valid, fp_req1_valid, fp_req0_ready, fp_req1_ready;
    logic [31:0] fp_alu_a, fp_alu_b, fp_alu_sum;
    logic [2:0]  fp_alu_gin;
    logic        fp_alu_zout, fp_alu_nin, fp_alu_vin;
    logic        fp_rsp_valid, fp_rsp_ready, fp_rsp_id, fp_rsp_z, fp_rsp_n, fp_rsp_v, fp_rsp_err;
    logic [31:0] fp_rsp_sum;

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural ALU: {v, n, z, sum}. Code 101 returns junk that must never reach rsp_*.
    function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] g);
        logic [31:0] s;
        logic        v;
        v = 1'b0;
        case (g)
            3'b010: begin s = a + b; v = (a[31] == b[31]) && (s[31] != a[31]); end
            3'b110: begin s = a - b; v = (a[31] != b[31]) && (s[31] != a[31]); end
            3'b111: s = {31'd0, ($signed(a) < $signed(b))};
            3'b000: s = a & b;
            3'b001: s = a | b;
            3'b100: s = ~(a | b);
            3'b011: s = ~(a & b);
            default: begin s = 32'hDEAD_BEEF; v = 1'b1; end
        endcase
        return {v, s[31], (s == 32'd0), s};
    endfunction

    assign {alu_vin, alu_nin, alu_zout, alu_sum}             = alu_f(alu_a, alu_b, alu_gin);
    assign {fp_alu_vin, fp_alu_nin, fp_alu_zout, fp_alu_sum} = alu_f(fp_alu_a, fp_alu_b, fp_alu_gin);

    alu_share_arbiter #(.FIX_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin), .alu_sum(alu_sum),
        .alu_zout(alu_zout), .alu_nin(alu_nin), .alu_vin(alu_vin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_v(rsp_v), .rsp_err(rsp_err)
    );

    alu_share_arbiter #(.FIX_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_gin(fp_alu_gin), .alu_sum(fp_alu_sum),
        .alu_zout(fp_alu_zout), .alu_nin(fp_alu_nin), .alu_vin(fp_alu_vin),
        .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_id(fp_rsp_id), .rsp_sum(fp_rsp_sum),
        .rsp_z(fp_rsp_z), .rsp_n(fp_rsp_n), .rsp_v(fp_rsp_v), .rsp_err(fp_rsp_err)
    );

    typedef struct packed {
        logic        v0;
        logic        v1;
        logic        rr;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [2:0]  op0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [2:0]  op1;
    } stim_t;

    // Transaction model: one op in flight, response visible from accept+2 until taken.
    bit          m_busy;
    bit          m_last;
    int          m_cyc;
    int          m_rsp_at;
    logic [31:0] e_a, e_b, e_sum;
    logic [2:0]  e_op;
    logic        e_id, e_z, e_n, e_v, e_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        fp_req0_valid = 1'b0; fp_req1_valid = 1'b0; fp_rsp_ready = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_rsp_flags", {rsp_z, rsp_n, rsp_v, rsp_err}, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_gin", alu_gin, 0);
        @(posedge clk);
        #1;
        check("rst_rsp_valid_held", rsp_valid, 0);
        m_busy = 1'b0;
        m_last = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, check just after, advance the model.
    task automatic cycle(input stim_t s);
        bit w, e_r0, e_r1, e_ex, e_rv;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = s.v0; req1_valid = s.v1; rsp_ready = s.rr;
        req0_a = s.a0; req0_b = s.b0; req0_op = s.op0;
        req1_a = s.a1; req1_b = s.b1; req1_op = s.op1;
        #1;
        w    = (s.v0 && s.v1) ? !m_last : s.v1;
        e_r0 = !m_busy && s.v0 && !w;
        e_r1 = !m_busy && s.v1 && w;
        e_ex = m_busy && (m_cyc == m_rsp_at - 1);
        e_rv = m_busy && (m_cyc >= m_rsp_at);
        check("req0_ready", req0_ready, e_r0);
        check("req1_ready", req1_ready, e_r1);
        check("alu_a", alu_a, e_ex ? e_a : 32'd0);
        check("alu_b", alu_b, e_ex ? e_b : 32'd0);
        check("alu_gin", alu_gin, e_ex ? e_op : 3'd0);
        check("rsp_valid", rsp_valid, e_rv);
        if (e_rv) begin
            check("rsp_id", rsp_id, e_id);
            check("rsp_sum", rsp_sum, e_sum);
            check("rsp_znv", {rsp_z, rsp_n, rsp_v}, {e_z, e_n, e_v});
            check("rsp_err", rsp_err, e_err);
        end
        if (e_rv && s.rr)
            m_busy = 1'b0;
        if (e_r0 || e_r1) begin
            m_busy   = 1'b1;
            m_rsp_at = m_cyc + 2;
            m_last   = w;
            e_id     = w;
            e_a      = w ? s.a1  : s.a0;
            e_b      = w ? s.b1  : s.b0;
            e_op     = w ? s.op1 : s.op0;
            if (e_op == 3'b101) begin
                {e_v, e_n, e_z, e_sum} = {1'b0, 1'b0, 1'b1, 32'd0};
                e_err = 1'b1;
            end else begin
                {e_v, e_n, e_z, e_sum} = alu_f(e_a, e_b, e_op);
                e_err = 1'b0;
            end
        end
        m_cyc++;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    stim_t s;
    stim_t s_idle;
    int    grants[$];
    int    rsp_cycles[$];

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
        fp_req0_valid = 1'b0; fp_req1_valid = 1'b0; fp_rsp_ready = 1'b0;
        m_cyc = 0; m_rsp_at = 0;
        s_idle = '0;
        s_idle.rr = 1'b1;

        // Reset state, then single ADD accepted on the first edge after release.
        do_reset();
        s = s_idle; s.v0 = 1'b1; s.a0 = 32'd5; s.b0 = 32'd7; s.op0 = 3'b010;
        cycle(s);
        check("add_accept", req0_ready, 1);
        cycle(s_idle);
        cycle(s_idle);
        check("add_valid", rsp_valid, 1);
        check("add_id", rsp_id, 0);
        check("add_sum", rsp_sum, 32'd12);
        check("add_flags", {rsp_z, rsp_n, rsp_v, rsp_err}, 0);
        repeat (2) cycle(s_idle);

        // Round-robin tie from a fresh reset: grants 0,1,0,1, responses 3 cycles apart.
        do_reset();
        s = s_idle; s.v0 = 1'b1; s.v1 = 1'b1;
        s.a0 = 32'd3; s.b0 = 32'hFFFF_FFFF; s.op0 = 3'b111;
        s.a1 = 32'h0F0F_0000; s.b1 = 32'h0000_F0F0; s.op1 = 3'b100;
        for (int i = 0; i < 12; i++) begin
            cycle(s);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp_valid) rsp_cycles.push_back(i);
        end
        check("tie_grant_count", grants.size(), 4);
        check("tie_rsp_count", rsp_cycles.size(), 4);
        for (int i = 0; i < grants.size(); i++)
            check("tie_grant_order", grants[i], i % 2);
        for (int i = 1; i < rsp_cycles.size(); i++)
            check("tie_rsp_spacing", rsp_cycles[i] - rsp_cycles[i-1], 3);
        repeat (3) cycle(s_idle);

        // Backpressure with SUB overflow; operands wiggle while busy.
        s = s_idle; s.rr = 1'b0; s.v1 = 1'b1;
        s.a1 = 32'h8000_0000; s.b1 = 32'd1; s.op1 = 3'b110;
        cycle(s);
        s.v0 = 1'b1; s.a0 = 32'd1; s.b0 = 32'd1; s.op0 = 3'b010;
        for (int i = 0; i < 6; i++) begin
            s.a1 = $urandom(); s.b1 = $urandom();
            cycle(s);
        end
        check("bp_sum", rsp_sum, 32'h7FFF_FFFF);
        check("bp_v", rsp_v, 1);
        check("bp_id", rsp_id, 1);
        check("bp_req0_blocked", req0_ready, 0);
        s = s_idle;
        cycle(s);
        cycle(s);
        check("bp_release", rsp_valid, 0);
        repeat (2) cycle(s_idle);

        // Unsupported op code.
        s = s_idle; s.v0 = 1'b1; s.a0 = $urandom(); s.b0 = $urandom(); s.op0 = 3'b101;
        cycle(s);
        cycle(s_idle);
        cycle(s_idle);
        check("bad_err", rsp_err, 1);
        check("bad_sum", rsp_sum, 0);
        check("bad_z", rsp_z, 1);
        repeat (2) cycle(s_idle);

        // Reset mid-EXEC: the op disappears and req0 wins the next tie.
        s = s_idle; s.v1 = 1'b1; s.a1 = 32'd9; s.b1 = 32'd4; s.op1 = 3'b001;
        cycle(s);
        do_reset();
        repeat (3) cycle(s_idle);
        check("abort_no_rsp", rsp_valid, 0);
        s = s_idle; s.v0 = 1'b1; s.v1 = 1'b1;
        cycle(s);
        check("abort_tie_req0", req0_ready, 1);
        repeat (3) cycle(s_idle);

        // Fixed-priority instance: req0 always wins a tie, req1 only when alone.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            fp_req0_valid = 1'b1; fp_req1_valid = 1'b1; fp_rsp_ready = 1'b1;
            #1;
            check("fp_req1_ready", fp_req1_ready, 0);
            check("fp_req0_ready", fp_req0_ready, (i % 3) == 0);
            if ((i % 3) == 2) check("fp_rsp_id", {fp_rsp_valid, fp_rsp_id}, 2'b10);
        end
        @(negedge clk);
        fp_req0_valid = 1'b0;
        #1;
        check("fp_req1_alone", fp_req1_ready, 1);
        @(negedge clk);
        fp_req1_valid = 1'b0;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            s.v0  = ($urandom_range(0, 1) == 1);
            s.v1  = ($urandom_range(0, 1) == 1);
            s.rr  = ($urandom_range(0, 9) < 6);
            s.a0  = rnd_operand(); s.b0 = rnd_operand(); s.op0 = 3'($urandom_range(0, 7));
            s.a1  = rnd_operand(); s.b1 = rnd_operand(); s.op1 = 3'($urandom_range(0, 7));
            cycle(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: FIX_PRIO, default 0, 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-007 req0_op / req1_op  input  3  ALU control code: 010 ADD, 110 SUB, 111 SLT, 000 AND, 001 OR, 100 NOR, 011 NAND.
REQ-008 alu_a, alu_b  output  32  operands driven to the shared ALU.
REQ-009 alu_gin  output  3  ALU control line driven to the shared ALU.
REQ-010 alu_sum  input  32  ALU result.
REQ-011 alu_zout, alu_nin, alu_vin  input  1  ALU zero, negative and overflow flags.
REQ-012 rsp_valid  output  1  a response is held.
REQ-013 rsp_ready  input  1  the consumer takes the response.
REQ-014 rsp_id  output  1  index of the requester that owns the response.
REQ-015 rsp_sum  output  32  registered result.
REQ-016 rsp_z, rsp_n, rsp_v  output  1  registered flags.
REQ-017 rsp_err  output  1  the op code was unsupported.

Function
REQ-018 States: IDLE, EXEC, RESP; exactly one operation is in flight at a time.
REQ-019 IDLE arbitration:
- FIX_PRIO=1: req0 wins whenever req0_valid=1.
- FIX_PRIO=0: with a single valid requester, that requester wins.
- FIX_PRIO=0: with both valid, the requester not equal to last_id wins.
REQ-020 reqN_ready is combinational and equals 1 only when state=IDLE, reqN_valid=1 and N is the winner; at most one ready is high per cycle.
REQ-021 On accept (IDLE, ready=1):
- the winner's a, b and op are captured into operand registers, and its index into owner_id;
- last_id is updated to the winner (both modes);
- next state is EXEC.
REQ-022 IDLE with no valid requester: the block stays in IDLE with both ready outputs 0.
REQ-023 In EXEC, alu_a, alu_b and alu_gin are driven from the operand registers; in IDLE and RESP they are driven to 0.
REQ-024 At the end of EXEC, alu_sum and the three ALU flags are captured into the rsp_* registers, rsp_id is set to owner_id, and the next state is RESP.
REQ-025 Unsupported op codes (101): rsp_err=1, rsp_sum=0, rsp_z=1, rsp_n=0, rsp_v=0; the ALU outputs are ignored.
REQ-026 Supported op codes give rsp_err=0.
REQ-027 In RESP, rsp_valid=1, and all rsp_* outputs stay stable until the cycle in which rsp_ready=1.
REQ-028 On RESP with rsp_ready=1, the next state is IDLE and rsp_valid falls on the next cycle.
REQ-029 Latency: accept at cycle T gives rsp_valid=1 at cycle T+2; with rsp_ready held 1, the next accept is possible at T+3.
REQ-030 rsp_valid=0 in IDLE and EXEC.
REQ-031 reqN_valid deasserting while not granted has no effect; requester inputs are sampled only in the accept cycle.
REQ-032 Any input change during EXEC or RESP does not alter the in-flight operation.

Reset
REQ-033 While rst_n=0:
- state=IDLE, last_id=1 so that requester 0 wins the first tie;
- owner_id=0, operand registers=0;
- rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_z=0, rsp_n=0, rsp_v=0, rsp_err=0.
REQ-034 A reset asserted during EXEC or RESP aborts the operation, and no response for it is ever presented.
REQ-035 The first accept after reset release can occur in the first clock edge with rst_n=1.

Verification
REQ-036 Single request: req0 ADD a=5, b=7 accepted at T -> at T+2, rsp_valid=1, rsp_id=0, rsp_sum=12, z=0, n=0, v=0, err=0.
REQ-037 Tie, round-robin: both requesters held valid continuously with rsp_ready=1 -> grants 0,1,0,1; each response appears 3 cycles after the previous one.
REQ-038 Fixed priority: with FIX_PRIO=1 and both valid -> req0 is granted every time, and req1_ready is never 1.
REQ-039 Backpressure and overflow: req1 SUB a=0x80000000, b=1 with rsp_ready=0 for 5 cycles -> rsp_sum=0x7FFFFFFF, v=1, held stable; req0_ready=0 throughout; release follows rsp_ready=1.
REQ-040 Bad op: req0 op=101 -> rsp_err=1, rsp_sum=0, rsp_z=1.
REQ-041 Reset mid-EXEC: rst_n=0 for one cycle -> rsp_valid stays 0, state=IDLE, and the next tie goes to req0.
